// File: rtl/parity_pkg.sv
// Shared types and the per-lane parity helper for the stream parity checker.
package parity_pkg;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stream_state_e;

  // Widest lane the helper handles; narrower lanes are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int MAX_LANE_W = 64;

  // Returns 1 when the lane plus its parity bit violates the selected mode.
  function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] data,
                                       input logic                  par,
                                       input parity_mode_e          mode);
    logic x;
    x = ^{data, par};
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/parity_lane_check.sv
// Combinational parity check of one lane against its parity bit.
module parity_lane_check
  import parity_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] i_data,
  input  logic              i_par,
  input  parity_mode_e      i_mode,
  output logic              o_err
);

  logic [MAX_LANE_W-1:0] w_data_ext;

  // Zero-extend the lane to the helper's fixed argument width.
  always_comb begin
    w_data_ext               = '0;
    w_data_ext[LANE_W-1:0]   = i_data;
  end

  assign o_err = lane_parity(w_data_ext, i_par, i_mode);

endmodule

// File: rtl/parity_checker_stream.sv
// Registered per-lane parity checker on a valid/ready stream with error statistics.
//
//  state    | meaning
//  ---------+------------------------------------------------
//  ST_EMPTY | output register holds no word, out_valid = 0
//  ST_FULL  | output register holds a checked word, out_valid = 1
module parity_checker_stream
  import parity_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16,
  localparam int LANES = DATA_W / LANE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_odd_mode,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [LANES-1:0]  i_in_parity,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [LANES-1:0]  o_out_lane_err,
  output logic              o_out_err,
  output logic              o_err_sticky,
  output logic [CNT_W-1:0]  o_err_count,
  input  logic [CNT_W-1:0]  i_err_thresh,
  output logic              o_err_alarm,
  input  logic              i_err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  parity_mode_e      w_mode;
  logic [LANES-1:0]  w_lane_err;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_word_err;
  logic [CNT_W-1:0]  w_cnt_inc;

  stream_state_e     r_state;
  logic [DATA_W-1:0] r_out_data;
  logic [LANES-1:0]  r_out_lane_err;
  logic              r_err_sticky;
  logic [CNT_W-1:0]  r_err_count;

  assign w_mode = parity_mode_e'(i_odd_mode);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    parity_lane_check #(
      .LANE_W (LANE_W)
    ) u_lane (
      .i_data (i_in_data[g*LANE_W +: LANE_W]),
      .i_par  (i_in_parity[g]),
      .i_mode (w_mode),
      .o_err  (w_lane_err[g])
    );
  end

  assign w_in_ready = (r_state == ST_EMPTY) | i_out_ready;
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_word_err = |w_lane_err;
  assign w_cnt_inc  = (r_err_count == CNT_MAX) ? r_err_count : r_err_count + CNT_W'(1);

  // Output register stage: load on accept, drain on out_ready, hold while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_EMPTY;
      r_out_data     <= '0;
      r_out_lane_err <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state        <= ST_FULL;
            r_out_data     <= i_in_data;
            r_out_lane_err <= w_lane_err;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            r_out_data     <= i_in_data;
            r_out_lane_err <= w_lane_err;
          end else if (i_out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Statistics count at accept time so a stalled word is only counted once;
  // an errored accept overrides a simultaneous clear and restarts at one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if (w_accept && w_word_err) begin
      r_err_sticky <= 1'b1;
      r_err_count  <= i_err_clr ? CNT_W'(1) : w_cnt_inc;
    end else if (i_err_clr) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_out_valid    = (r_state == ST_FULL);
  assign o_out_data     = r_out_data;
  assign o_out_lane_err = r_out_lane_err;
  assign o_out_err      = |r_out_lane_err;
  assign o_err_sticky   = r_err_sticky;
  assign o_err_count    = r_err_count;
  assign o_err_alarm    = (i_err_thresh != '0) && (r_err_count >= i_err_thresh);

endmodule

// File: tb/tb_parity_checker_stream.sv
// Directed scoreboard bench for parity_checker_stream (default and 4-bit counter instances).
module tb_parity_checker_stream;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  lerr;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst, odd, in_valid, out_ready, err_clr;
  logic [31:0] in_data;
  logic [3:0]  in_par;
  logic [15:0] thresh;
  logic [3:0]  thresh4;

  logic        in_ready, out_valid, out_err, sticky, alarm;
  logic [31:0] out_data;
  logic [3:0]  out_lerr;
  logic [15:0] cnt;

  logic        in_ready4, out_valid4, out_err4, sticky4, alarm4;
  logic [31:0] out_data4;
  logic [3:0]  out_lerr4;
  logic [3:0]  cnt4;

  sb_t sb_q[$];
  bit  m_full, m_sticky;
  int  m_cnt, m_cnt4;
  int  n_vec  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  parity_checker_stream dut (
    .i_clk(clk), .i_rst(rst), .i_odd_mode(odd), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_parity(in_par), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_lane_err(out_lerr), .o_out_err(out_err), .o_err_sticky(sticky),
    .o_err_count(cnt), .i_err_thresh(thresh), .o_err_alarm(alarm), .i_err_clr(err_clr)
  );

  parity_checker_stream #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_odd_mode(odd), .i_in_valid(in_valid), .o_in_ready(in_ready4),
    .i_in_data(in_data), .i_in_parity(in_par), .o_out_valid(out_valid4), .i_out_ready(out_ready),
    .o_out_data(out_data4), .o_out_lane_err(out_lerr4), .o_out_err(out_err4), .o_err_sticky(sticky4),
    .o_err_count(cnt4), .i_err_thresh(thresh4), .o_err_alarm(alarm4), .i_err_clr(err_clr)
  );

  function automatic logic [3:0] model_lerr(logic [31:0] d, logic [3:0] p, logic o);
    logic [3:0] r;
    logic       x;
    for (int l = 0; l < 4; l++) begin
      x = p[l];
      for (int b = 0; b < 8; b++) x = x ^ d[l*8+b];
      r[l] = o ? ~x : x;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 32'(out_valid), 32'(m_full));
    if (m_full) begin
      chk("out_data", out_data, sb_q[0].data);
      chk("out_lane_err", 32'(out_lerr), 32'(sb_q[0].lerr));
      chk("out_err", 32'(out_err), 32'(|sb_q[0].lerr));
    end
    chk("err_count", 32'(cnt), 32'(m_cnt));
    chk("err_sticky", 32'(sticky), 32'(m_sticky));
    chk("err_alarm", 32'(alarm), 32'((thresh != 0) && (m_cnt >= int'(thresh))));
    chk("err_count4", 32'(cnt4), 32'(m_cnt4));
    chk("err_sticky4", 32'(sticky4), 32'(m_sticky));
    chk("err_alarm4", 32'(alarm4), 32'((thresh4 != 0) && (m_cnt4 >= int'(thresh4))));
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] p,
                      input logic o, input logic rdy, input logic clr);
    logic [3:0] le;
    logic       acc, exp_rdy;
    @(negedge clk);
    in_valid = v; in_data = d; in_par = p; odd = o; out_ready = rdy; err_clr = clr;
    #1;
    exp_rdy = !m_full || rdy;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    le  = model_lerr(d, p, o);
    acc = v && exp_rdy;
    if (m_full && rdy) void'(sb_q.pop_front());
    if (acc) begin
      sb_q.push_back('{data: d, lerr: le});
      m_full = 1'b1;
    end else if (rdy) begin
      m_full = 1'b0;
    end
    if (acc && (|le)) begin
      m_sticky = 1'b1;
      m_cnt    = clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
      m_cnt4   = clr ? 1 : ((m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4);
    end else if (clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
      m_cnt4   = 0;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; err_clr = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_lane_err", 32'(out_lerr), 32'd0);
    chk("rst_err_count", 32'(cnt), 32'd0);
    chk("rst_err_sticky", 32'(sticky), 32'd0);
    sb_q.delete();
    m_full = 1'b0; m_sticky = 1'b0; m_cnt = 0; m_cnt4 = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; odd = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_data = '0; in_par = '0; thresh = '0; thresh4 = 4'd3;
    m_full = 1'b0; m_sticky = 1'b0; m_cnt = 0; m_cnt4 = 0;
    #12;
    do_reset();

    // Even mode, clean word, then drain
    step(1'b1, 32'h0000_0080, 4'b0001, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0);

    // Even mode errored words, back to back
    step(1'b1, 32'h0000_01B7, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_01B6, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hFF00_0301, 4'b1010, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0);

    // Odd mode
    step(1'b1, 32'h0000_0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0000, 4'b1110, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h8001_0300, 4'b1001, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0);

    // Stall with an errored word pending and a waiting producer
    step(1'b1, 32'h0000_01B6, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0001, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0);

    // Clear alone, clear with clean accept, clear against errored accept
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0001, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0080, 4'b0001, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0003, 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0001, 4'b0000, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0);

    // Saturation of the 4-bit counter and alarm thresholds
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b1);
    thresh = 16'd10;
    for (int i = 0; i < 20; i++)
      step(1'b1, 32'h0100_0000 | 32'(i), {3'b000, ~^i[7:0]}, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0);
    thresh = 16'd0;
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0);

    // Reset while a word is held
    step(1'b1, 32'hDEAD_BEEF, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 32'h0000_0080, 4'b0001, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
